// File: rtl/swc_page_alloc_arbiter_pkg.sv
// Shared FSM encoding, op types and watchdog limit for the page-allocator arbiter.
// The watchdog is only used when SWC_PA_ARB_TIMEOUT_EN is defined.
package swc_pa_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  typedef enum logic {
    OP_ALLOC = 1'b0,
    OP_FREE  = 1'b1
  } op_t;

  localparam int unsigned C_WDOG_LIMIT = 255;

  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/swc_page_alloc_arbiter_if.sv
// Requester-side and allocator-side signals of the page-allocator arbiter.
// err_o exists only when SWC_PA_ARB_TIMEOUT_EN is defined.
interface swc_page_alloc_arbiter_if #(
  parameter int g_num_ports      = 4,
  parameter int g_page_addr_bits = 11,
  parameter int g_use_count_bits = 4
);
  logic [g_num_ports-1:0]                  req_alloc_i;
  logic [g_num_ports-1:0]                  req_free_i;
  logic [g_num_ports*g_page_addr_bits-1:0] req_pgaddr_i;
  logic [g_num_ports*g_use_count_bits-1:0] req_usecnt_i;
  logic [g_num_ports-1:0]                  ack_o;
  logic [g_page_addr_bits-1:0]             pgaddr_o;
  logic                                    nomem_o;
  logic                                    pa_alloc_o;
  logic                                    pa_free_o;
  logic [g_page_addr_bits-1:0]             pa_pgaddr_o;
  logic [g_use_count_bits-1:0]             pa_usecnt_o;
  logic [g_page_addr_bits-1:0]             pa_pgaddr_i;
  logic                                    pa_pgaddr_valid_i;
  logic                                    pa_nomem_i;
  logic                                    pa_idle_i;
`ifdef SWC_PA_ARB_TIMEOUT_EN
  logic                                    err_o;

  modport slave (
    input  req_alloc_i, req_free_i, req_pgaddr_i, req_usecnt_i,
    input  pa_pgaddr_i, pa_pgaddr_valid_i, pa_nomem_i, pa_idle_i,
    output ack_o, pgaddr_o, nomem_o, pa_alloc_o, pa_free_o, pa_pgaddr_o, pa_usecnt_o, err_o
  );

  modport master (
    output req_alloc_i, req_free_i, req_pgaddr_i, req_usecnt_i,
    output pa_pgaddr_i, pa_pgaddr_valid_i, pa_nomem_i, pa_idle_i,
    input  ack_o, pgaddr_o, nomem_o, pa_alloc_o, pa_free_o, pa_pgaddr_o, pa_usecnt_o, err_o
  );
`else
  modport slave (
    input  req_alloc_i, req_free_i, req_pgaddr_i, req_usecnt_i,
    input  pa_pgaddr_i, pa_pgaddr_valid_i, pa_nomem_i, pa_idle_i,
    output ack_o, pgaddr_o, nomem_o, pa_alloc_o, pa_free_o, pa_pgaddr_o, pa_usecnt_o
  );

  modport master (
    output req_alloc_i, req_free_i, req_pgaddr_i, req_usecnt_i,
    output pa_pgaddr_i, pa_pgaddr_valid_i, pa_nomem_i, pa_idle_i,
    input  ack_o, pgaddr_o, nomem_o, pa_alloc_o, pa_free_o, pa_pgaddr_o, pa_usecnt_o
  );
`endif
endinterface

// File: rtl/swc_page_alloc_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
// Reusable by any switch-core arbiter; it holds no state.
module swc_rr_picker #(
  parameter int g_num_ports = 4
) (
  input  logic [g_num_ports-1:0]         i_req,
  input  logic [$clog2(g_num_ports)-1:0] i_ptr,
  output logic [g_num_ports-1:0]         o_grant,
  output logic [$clog2(g_num_ports)-1:0] o_idx,
  output logic                           o_valid
);

  localparam int W = $clog2(g_num_ports);

  int unsigned  w_k;
  logic [W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = 0;
    w_cand  = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      w_k    = (32'(i_ptr) + 32'(i)) % 32'(g_num_ports);
      w_cand = W'(w_k);
      if (!o_valid && i_req[w_cand]) begin
        o_valid         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/swc_page_alloc_arbiter.sv
// Round-robin arbiter sharing one swc_page_allocator among g_num_ports requesters.
// Define SWC_PA_ARB_TIMEOUT_EN to add the S_WAIT watchdog and err_o.
module swc_page_alloc_arbiter
  import swc_pa_arb_pkg::*;
#(
  parameter int g_num_ports      = 4,
  parameter int g_page_addr_bits = 11,
  parameter int g_use_count_bits = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  swc_page_alloc_arbiter_if.slave  io_bus
);

  localparam int N = g_num_ports;
  localparam int A = g_page_addr_bits;
  localparam int U = g_use_count_bits;
  localparam int W = $clog2(g_num_ports);

  state_t       r_state;
  state_t       w_next;
  op_t          r_op;
  logic [W-1:0] r_ptr;
  logic [W-1:0] r_port;
  logic [N-1:0] r_grant;
  logic [A-1:0] r_pa_pgaddr;
  logic [U-1:0] r_pa_usecnt;
  logic [A-1:0] r_captured;
  logic [A-1:0] r_pgaddr_out;
  logic         r_nomem;

  logic [N-1:0] w_eligible;
  logic [N-1:0] w_grant;
  logic [W-1:0] w_idx;
  logic         w_any;
  logic         w_sel_free;
  logic [A-1:0] w_sel_pgaddr;
  logic [U-1:0] w_sel_usecnt;
  logic [A-1:0] w_page;

`ifdef SWC_PA_ARB_TIMEOUT_EN
  logic [7:0]   r_wdog;
  logic         w_timeout;
`endif

  // Alloc-only requests are skipped while the allocator is out of pages.
  assign w_eligible   = io_bus.req_free_i | (io_bus.req_alloc_i & {N{~io_bus.pa_nomem_i}});
  assign w_sel_free   = io_bus.req_free_i[w_idx];
  assign w_sel_pgaddr = io_bus.req_pgaddr_i[32'(w_idx) * A +: A];
  assign w_sel_usecnt = io_bus.req_usecnt_i[32'(w_idx) * U +: U];
  assign w_page       = io_bus.pa_pgaddr_valid_i ? io_bus.pa_pgaddr_i : r_captured;

  swc_rr_picker #(
    .g_num_ports (N)
  ) u_picker (
    .i_req   (w_eligible),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign io_bus.pgaddr_o    = r_pgaddr_out;
  assign io_bus.nomem_o     = r_nomem;
  assign io_bus.pa_pgaddr_o = r_pa_pgaddr;
  assign io_bus.pa_usecnt_o = r_pa_usecnt;
`ifdef SWC_PA_ARB_TIMEOUT_EN
  assign io_bus.err_o       = w_timeout;
`endif

  always_comb begin
    w_next            = r_state;
    io_bus.pa_alloc_o = 1'b0;
    io_bus.pa_free_o  = 1'b0;
    io_bus.ack_o      = '0;
`ifdef SWC_PA_ARB_TIMEOUT_EN
    w_timeout         = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (io_bus.pa_idle_i && w_any) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        io_bus.pa_alloc_o = (r_op == OP_ALLOC);
        io_bus.pa_free_o  = (r_op == OP_FREE);
        w_next            = S_WAIT;
      end
      S_WAIT: begin
        if (io_bus.pa_idle_i) begin
          w_next = S_ACK;
        end
`ifdef SWC_PA_ARB_TIMEOUT_EN
        else if (r_wdog == 8'(C_WDOG_LIMIT)) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
`endif
      end
      S_ACK: begin
        io_bus.ack_o = r_grant;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= OP_ALLOC;
      r_ptr        <= '0;
      r_port       <= '0;
      r_grant      <= '0;
      r_pa_pgaddr  <= '0;
      r_pa_usecnt  <= '0;
      r_captured   <= '0;
      r_pgaddr_out <= '0;
      r_nomem      <= 1'b0;
`ifdef SWC_PA_ARB_TIMEOUT_EN
      r_wdog       <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_nomem <= io_bus.pa_nomem_i;
      case (r_state)
        S_IDLE: begin
          if (w_next == S_ISSUE) begin
            r_port      <= w_idx;
            r_grant     <= w_grant;
            r_op        <= w_sel_free ? OP_FREE : OP_ALLOC;
            r_pa_pgaddr <= w_sel_pgaddr;
            r_pa_usecnt <= w_sel_usecnt;
          end
        end
        S_ISSUE: begin
`ifdef SWC_PA_ARB_TIMEOUT_EN
          r_wdog <= '0;
`endif
        end
        S_WAIT: begin
          if (io_bus.pa_pgaddr_valid_i) r_captured <= io_bus.pa_pgaddr_i;
          // Result and idle may arrive together, so the ack value bypasses r_captured.
          if (w_next == S_ACK) r_pgaddr_out <= (r_op == OP_ALLOC) ? w_page : r_pa_pgaddr;
`ifdef SWC_PA_ARB_TIMEOUT_EN
          r_wdog <= r_wdog + 8'd1;
          if (w_timeout) r_ptr <= W'(rr_next(32'(r_port), N));
`endif
        end
        S_ACK: begin
          r_ptr <= W'(rr_next(32'(r_port), N));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swc_page_alloc_arbiter.sv
// Self-checking bench for swc_page_alloc_arbiter with a LIFO free-stack allocator model.
// The watchdog sequence runs only when SWC_PA_ARB_TIMEOUT_EN is defined.
module tb_swc_page_alloc_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  swc_page_alloc_arbiter_if #(4, 11, 4) bus ();

  swc_page_alloc_arbiter #(
    .g_num_ports      (4),
    .g_page_addr_bits (11),
    .g_use_count_bits (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Allocator model: pops from the front on alloc, pushes freed pages back on the front.
  logic [10:0] freeStack[$];
  logic        mBusy, mValid, mOpFree, mNomem;
  logic [10:0] mPage, mAddr;
  int          mCnt;
  int          busyCycles = 1;
  bit          forceBusy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      freeStack.delete();
      for (int i = 0; i < 2048; i++) freeStack.push_back(11'(i));
      mBusy <= 1'b0; mValid <= 1'b0; mOpFree <= 1'b0; mNomem <= 1'b0;
      mPage <= '0; mAddr <= '0; mCnt <= 0;
    end else begin
      mValid <= 1'b0;
      if (mBusy) begin
        if (mCnt == 0) begin
          mBusy <= 1'b0;
          if (mOpFree) freeStack.push_front(mAddr);
          else if (freeStack.size() > 0) begin
            mPage  <= freeStack.pop_front();
            mValid <= 1'b1;
          end
        end else mCnt <= mCnt - 1;
      end else if (bus.pa_alloc_o || bus.pa_free_o) begin
        mBusy   <= 1'b1;
        mCnt    <= busyCycles;
        mOpFree <= bus.pa_free_o;
        mAddr   <= bus.pa_pgaddr_o;
      end
      mNomem <= (freeStack.size() == 0);
    end
  end

  assign bus.pa_idle_i         = !mBusy && !forceBusy;
  assign bus.pa_pgaddr_valid_i = mValid;
  assign bus.pa_pgaddr_i       = mPage;
  assign bus.pa_nomem_i        = mNomem;

  int allocPulses = 0;
  int freePulses  = 0;
  always @(posedge clk) begin
    if (bus.pa_alloc_o) allocPulses++;
    if (bus.pa_free_o)  freePulses++;
  end

  typedef struct {
    string       name;
    logic [3:0]  alloc;
    logic [3:0]  free;
    logic [43:0] addrs;
    logic [3:0]  expAck;
    logic [10:0] expPage;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [43:0] packAddr(int a0, int a1, int a2, int a3);
    return {11'(a3), 11'(a2), 11'(a1), 11'(a0)};
  endfunction

  function automatic vec_t mkVec(string n, logic [3:0] al, logic [3:0] fr, logic [43:0] ad,
                                 logic [3:0] ea, int ep);
    vec_t v;
    v.name = n; v.alloc = al; v.free = fr; v.addrs = ad; v.expAck = ea; v.expPage = 11'(ep);
    return v;
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(vec_t v);
    bus.req_alloc_i  = v.alloc;
    bus.req_free_i   = v.free;
    bus.req_pgaddr_i = v.addrs;
    bus.req_usecnt_i = {4{4'd1}};
  endtask

  task automatic clearReq();
    bus.req_alloc_i = '0;
    bus.req_free_i  = '0;
  endtask

  task automatic waitAck(output logic [3:0] ack, output logic [10:0] page, output bit seen);
    seen = 1'b0; ack = '0; page = '0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      if (bus.ack_o != '0) begin
        seen = 1'b1; ack = bus.ack_o; page = bus.pgaddr_o;
      end
    end
  endtask

  task automatic expectAck(string name, logic [3:0] expAck, int expPage);
    logic [3:0]  ack;
    logic [10:0] page;
    bit          seen;
    waitAck(ack, page, seen);
    checkOutput({name, " seen"}, 32'(seen), 32'd1);
    checkOutput({name, " ack"}, 32'(ack), 32'(expAck));
    checkOutput({name, " pgaddr"}, 32'(page), 32'(expPage));
  endtask

  task automatic runRows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      applyStimulus(vecs[i]);
      expectAck(vecs[i].name, vecs[i].expAck, int'(vecs[i].expPage));
    end
  endtask

  task automatic allocRun(string name, int count, int firstPage);
    logic [3:0]  ack;
    logic [10:0] page;
    bit          seen;
    int          bad = 0;
    bus.req_free_i  = '0;
    bus.req_alloc_i = 4'b0001;
    for (int i = 0; i < count; i++) begin
      waitAck(ack, page, seen);
      if (!seen || ack != 4'b0001 || page != 11'(firstPage + i)) bad++;
    end
    clearReq();
    checkOutput({name, " bad acks"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL global timeout");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    bit ackDuring;
    bit seen;

    vecs[0] = mkVec("t1 port0", 4'b1111, 4'b0000, packAddr(0, 0, 0, 0),  4'b0001, 0);
    vecs[1] = mkVec("t1 port1", 4'b1110, 4'b0000, packAddr(0, 0, 0, 0),  4'b0010, 1);
    vecs[2] = mkVec("t1 port2", 4'b1100, 4'b0000, packAddr(0, 0, 0, 0),  4'b0100, 2);
    vecs[3] = mkVec("t1 port3", 4'b1000, 4'b0000, packAddr(0, 0, 0, 0),  4'b1000, 3);
    vecs[4] = mkVec("t2 free50", 4'b0000, 4'b0110, packAddr(0, 50, 10, 0), 4'b0010, 50);
    vecs[5] = mkVec("t2 free10", 4'b0000, 4'b0100, packAddr(0, 50, 10, 0), 4'b0100, 10);
    vecs[6] = mkVec("t2 realloc10", 4'b0001, 4'b0000, packAddr(0, 0, 0, 0), 4'b0001, 10);
    vecs[7] = mkVec("t2 realloc50", 4'b0001, 4'b0000, packAddr(0, 0, 0, 0), 4'b0001, 50);
    vecs[8] = mkVec("t3 free first", 4'b0001, 4'b0001, packAddr(5, 0, 0, 0), 4'b0001, 5);
    vecs[9] = mkVec("t3 alloc after", 4'b0001, 4'b0000, packAddr(0, 0, 0, 0), 4'b0001, 5);

    bus.req_alloc_i  = '0;
    bus.req_free_i   = '0;
    bus.req_pgaddr_i = '0;
    bus.req_usecnt_i = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset ack", 32'(bus.ack_o), 32'd0);
    checkOutput("reset strobes", 32'({bus.pa_alloc_o, bus.pa_free_o}), 32'd0);
    checkOutput("reset pgaddr", 32'(bus.pgaddr_o), 32'd0);
    rst = 1'b0;

    runRows(0, 3);
    checkOutput("t1 alloc pulses", 32'(allocPulses), 32'd4);

    allocRun("fill 4..59", 56, 4);
    runRows(4, 9);
    checkOutput("t2/t3 free pulses", 32'(freePulses), 32'd3);

    allocRun("exhaust 60..2047", 1988, 60);
    repeat (3) @(negedge clk);
    checkOutput("t4 nomem_o", 32'(bus.nomem_o), 32'd1);
    bus.req_alloc_i  = 4'b1000;
    bus.req_free_i   = 4'b0010;
    bus.req_pgaddr_i = packAddr(0, 7, 0, 0);
    expectAck("t4 free7 while nomem", 4'b0010, 7);
    bus.req_free_i = '0;
    expectAck("t4 port3 gets 7", 4'b1000, 7);
    clearReq();

    bus.req_free_i   = 4'b0100;
    bus.req_pgaddr_i = packAddr(0, 0, 7, 0);
    expectAck("t5 setup free7", 4'b0100, 7);
    clearReq();
    busyCycles       = 20;
    bus.req_alloc_i  = 4'b1010;
    bus.req_pgaddr_i = packAddr(0, 0, 0, 33);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.pa_alloc_o) seen = 1'b1;
    end
    checkOutput("t5 strobe seen", 32'(seen), 32'd1);
    checkOutput("t5 issued pgaddr", 32'(bus.pa_pgaddr_o), 32'd33);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5 rst pgaddr_o", 32'(bus.pgaddr_o), 32'd0);
    checkOutput("t5 rst pa_pgaddr_o", 32'(bus.pa_pgaddr_o), 32'd0);
    checkOutput("t5 rst pa_usecnt_o", 32'(bus.pa_usecnt_o), 32'd0);
    checkOutput("t5 rst ack/strobes", 32'({bus.ack_o, bus.pa_alloc_o, bus.pa_free_o, bus.nomem_o}), 32'd0);
    ackDuring = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.ack_o != '0) ackDuring = 1'b1;
    end
    busyCycles = 1;
    rst = 1'b0;
    checkOutput("t5 no ack in reset", 32'(ackDuring), 32'd0);
    expectAck("t5 port1 first", 4'b0010, 0);
    bus.req_alloc_i = 4'b1000;
    expectAck("t5 port3 next", 4'b1000, 1);
    clearReq();

`ifdef SWC_PA_ARB_TIMEOUT_EN
    begin
      int errAt = 0;
      bus.req_alloc_i = 4'b0001;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        if (bus.pa_alloc_o) seen = 1'b1;
      end
      forceBusy = 1'b1;
      ackDuring = 1'b0;
      for (int c = 1; c <= 400 && errAt == 0; c++) begin
        @(negedge clk);
        if (bus.ack_o != '0) ackDuring = 1'b1;
        if (bus.err_o) errAt = c;
      end
      checkOutput("t6 err cycle", 32'(errAt), 32'd256);
      checkOutput("t6 no ack", 32'(ackDuring), 32'd0);
      bus.req_alloc_i = 4'b0011;
      forceBusy = 1'b0;
      expectAck("t6 pointer advanced", 4'b0010, 3);
      clearReq();
    end
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/swc_page_alloc_arbiter.md
Name: swc_page_alloc_arbiter

Overview:
- Shares one swc_page_allocator among g_num_ports requesters (input block ports, free logic).
- Round-robin arbitration over per-port alloc/free requests.
- Drives one allocator command at a time, waits for the allocator idle, then returns the page address and a one-cycle ack to the winning port.
- Sits between the switch-core ports and the page allocator.

Parameters:
- g_num_ports, 4, number of requesters (2..16)
- g_page_addr_bits, 11, page address width
- g_use_count_bits, 4, use-count width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_alloc_i  in  g_num_ports  per-port alloc request, level, held until ack
- req_free_i  in  g_num_ports  per-port free request, level, held until ack
- req_pgaddr_i  in  g_num_ports*g_page_addr_bits  page to free; port p at bits [p*A +: A]
- req_usecnt_i  in  g_num_ports*g_use_count_bits  use count for alloc; port p at [p*U +: U]
- ack_o  out  g_num_ports  one-cycle completion pulse, one-hot
- pgaddr_o  out  g_page_addr_bits  allocated page, valid with ack of an alloc
- nomem_o  out  1  registered copy of pa_nomem_i
- pa_alloc_o  out  1  allocator alloc strobe
- pa_free_o  out  1  allocator free strobe
- pa_pgaddr_o  out  g_page_addr_bits  page to free
- pa_usecnt_o  out  g_use_count_bits  use count
- pa_pgaddr_i  in  g_page_addr_bits  allocator result
- pa_pgaddr_valid_i  in  1  allocator result valid
- pa_nomem_i  in  1  allocator out of pages
- pa_idle_i  in  1  allocator idle

Behaviour:
- Reset: every output 0; FSM to S_IDLE; round-robin pointer to 0; captured page to 0.
- Reset asserted mid-operation aborts the operation with no ack. Requesters must re-request.
- Eligible request on port p = req_free_i[p] OR (req_alloc_i[p] AND NOT pa_nomem_i).
- FSM states:
  - S_IDLE: if pa_idle_i=1 and any port is eligible, pick the first eligible port at or after the pointer (wrap at g_num_ports-1 to 0). Latch the port index, op type, pgaddr and usecnt. Go to S_ISSUE.
  - S_ISSUE: assert pa_free_o or pa_alloc_o for exactly one cycle, with pa_pgaddr_o/pa_usecnt_o stable. Go to S_WAIT.
  - S_WAIT: on pa_pgaddr_valid_i=1, capture pa_pgaddr_i. When pa_idle_i=1 (earliest one cycle after the strobe), go to S_ACK.
  - S_ACK: ack_o[granted]=1 for one cycle; pgaddr_o = captured page (alloc) or the freed address (free). Pointer = granted+1 mod N. Go to S_IDLE.
- Minimum latency from request (in S_IDLE) to ack: 3 cycles plus allocator busy time.
- pa_pgaddr_o/pa_usecnt_o hold their last value outside S_ISSUE; the strobes are 0 outside S_ISSUE.
- Same port with both alloc and free asserted: free served first and acked. Alloc stays pending and competes in a later round.
- pa_nomem_i=1: alloc-only requests are skipped, not blocked; frees still proceed. A free clears nomem and re-enables allocs.
- A request deasserted before ack is a requester protocol violation; the latched operation completes anyway.
- pgaddr_o holds its value until the next ack.

Optional Feature:
SWC_PA_ARB_TIMEOUT_EN
- Defined:
  - Adds output err_o (1 bit) and an 8-bit watchdog counter in S_WAIT.
  - If pa_idle_i is still 0 after 255 cycles: pulse err_o for one cycle, return to S_IDLE with no ack to the port, and advance the pointer.
  - Counter clears on entry to S_WAIT.
- Undefined: no err_o port, no counter; S_WAIT waits indefinitely.

Decomposition:
- Shared package swc_pa_arb_pkg holds:
  - FSM state encoding (S_IDLE, S_ISSUE, S_WAIT, S_ACK)
  - op-type constants (OP_ALLOC, OP_FREE)
  - timeout constant 255
- One natural sub-module: swc_rr_picker. It is combinational: a request vector plus pointer gives a one-hot grant and an index. It is reusable by other switch-core arbiters.

Test Plan:
1. N=4; ports 0..3 alloc (usecnt 1) together, pointer 0 -> acks in order 0,1,2,3; pgaddr_o 0,1,2,3 on a fresh allocator; one pa_alloc_o pulse each.
2. Port 2 frees page 10, port 1 frees page 50, both simultaneous -> port 1 acked first, then port 2. The next alloc returns 10 or 50 per the allocator's free order, never a page still in use.
3. Port 0 asserts alloc+free (pgaddr 5) together -> free ack first; alloc acked in a later cycle with a valid page.
4. Exhaust all 2048 pages -> nomem_o=1. Port 3 alloc stays unacked while port 1's free of page 7 is acked. Port 3 then gets page 7.
5. rst asserted while in S_WAIT -> all outputs 0 next edge, no ack. After rst release the pending request is re-served from port 0.
6. SWC_PA_ARB_TIMEOUT_EN with pa_idle_i forced low -> err_o pulses 255 cycles into S_WAIT, no ack, pointer advances by one.
